// File: rtl/xc_rf_wb_arb.sv
// xc_rf_wb_arb: round-robin write-port arbiter that splits paired 64-bit writes into two register-file slots
module xc_rf_wb_arb (
  input  logic        clock,
  input  logic        resetn,
  input  logic        s0_valid,
  output logic        s0_ready,
  input  logic        s0_wide,
  input  logic [4:0]  s0_addr,
  input  logic [31:0] s0_wdata_lo,
  input  logic [31:0] s0_wdata_hi,
  input  logic        s1_valid,
  output logic        s1_ready,
  input  logic        s1_wide,
  input  logic [4:0]  s1_addr,
  input  logic [31:0] s1_wdata_lo,
  input  logic [31:0] s1_wdata_hi,
  output logic        rd_wen,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_wdata,
  output logic        busy_hi
);
  typedef enum logic [1:0] {IDLE, WR, LO} state_t;
  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        rd_wen_q, rd_wen_d;
  logic [4:0]  rd_addr_q, rd_addr_d, hi_addr_q, hi_addr_d;
  logic [31:0] rd_wdata_q, rd_wdata_d, hi_data_q, hi_data_d;
  logic        hold, acc, sel, wide;
  logic [4:0]  addr, p;
  logic [31:0] lo, hi;

  // Grant, mux the winning request, and compute the next write-port slot
  always_comb begin
    hold       = (state_q == LO);
    s0_ready   = !hold && s0_valid && (!s1_valid || last_q);
    s1_ready   = !hold && s1_valid && (!s0_valid || !last_q);
    acc        = s0_ready || s1_ready;
    sel        = s1_ready;
    wide       = sel ? s1_wide : s0_wide;
    addr       = sel ? s1_addr : s0_addr;
    lo         = sel ? s1_wdata_lo : s0_wdata_lo;
    hi         = sel ? s1_wdata_hi : s0_wdata_hi;
    p          = wide ? {addr[4:1], 1'b0} : addr;
    state_d    = hold ? WR : (acc ? (wide ? LO : WR) : IDLE);
    rd_wen_d   = hold ? 1'b1 : (acc && (p != 5'd0));
    rd_addr_d  = hold ? hi_addr_q : (acc ? p : rd_addr_q);
    rd_wdata_d = hold ? hi_data_q : (acc ? lo : rd_wdata_q);
    hi_addr_d  = (acc && wide) ? (p | 5'd1) : hi_addr_q;
    hi_data_d  = (acc && wide) ? hi : hi_data_q;
    last_d     = acc ? sel : last_q;
  end

  // State and registered write-port outputs; reset drops any pending odd half
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      rd_wen_q   <= 1'b0;
      rd_addr_q  <= 5'd0;
      rd_wdata_q <= 32'd0;
      hi_addr_q  <= 5'd0;
      hi_data_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      rd_wen_q   <= rd_wen_d;
      rd_addr_q  <= rd_addr_d;
      rd_wdata_q <= rd_wdata_d;
      hi_addr_q  <= hi_addr_d;
      hi_data_q  <= hi_data_d;
    end
  end

  assign rd_wen   = rd_wen_q;
  assign rd_addr  = rd_addr_q;
  assign rd_wdata = rd_wdata_q;
  assign busy_hi  = (state_q == LO);
endmodule

// File: tb/tb_xc_rf_wb_arb.sv
// tb_xc_rf_wb_arb: directed self-checking bench for the register-file write-port arbiter
module tb_xc_rf_wb_arb;
  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        s0_valid = 1'b0, s0_ready, s0_wide = 1'b0;
  logic [4:0]  s0_addr = 5'd0;
  logic [31:0] s0_wdata_lo = 32'd0, s0_wdata_hi = 32'd0;
  logic        s1_valid = 1'b0, s1_ready, s1_wide = 1'b0;
  logic [4:0]  s1_addr = 5'd0;
  logic [31:0] s1_wdata_lo = 32'd0, s1_wdata_hi = 32'd0;
  logic        rd_wen, busy_hi;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  int checks = 0, errors = 0;

  always #5 clock = ~clock;

  xc_rf_wb_arb dut (
    .clock(clock), .resetn(resetn),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_wide(s0_wide), .s0_addr(s0_addr),
    .s0_wdata_lo(s0_wdata_lo), .s0_wdata_hi(s0_wdata_hi),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_wide(s1_wide), .s1_addr(s1_addr),
    .s1_wdata_lo(s1_wdata_lo), .s1_wdata_hi(s1_wdata_hi),
    .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_wdata(rd_wdata), .busy_hi(busy_hi)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic src0(input logic v, input logic w, input logic [4:0] a, input logic [31:0] l, input logic [31:0] h);
    s0_valid = v; s0_wide = w; s0_addr = a; s0_wdata_lo = l; s0_wdata_hi = h;
  endtask

  task automatic src1(input logic v, input logic w, input logic [4:0] a, input logic [31:0] l, input logic [31:0] h);
    s1_valid = v; s1_wide = w; s1_addr = a; s1_wdata_lo = l; s1_wdata_hi = h;
  endtask

  task automatic chk_rd(input string tag, input logic w, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_wen"}, 32'(rd_wen), 32'(w));
    chk({tag, "_addr"}, 32'(rd_addr), 32'(a));
    chk({tag, "_data"}, rd_wdata, d);
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    chk({tag, "_r0"}, 32'(s0_ready), 32'(r0));
    chk({tag, "_r1"}, 32'(s1_ready), 32'(r1));
  endtask

  initial begin
    #2;
    chk_rd("reset", 1'b0, 5'd0, 32'd0);
    chk("reset_busy", 32'(busy_hi), 32'd0);
    chk_rdy("reset", 1'b0, 1'b0);
    tick();
    resetn = 1'b1;
    tick();
    // single write from source 0
    src0(1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0);
    #1 chk_rdy("single", 1'b1, 1'b0);
    tick();
    src0(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    chk_rd("single_wr", 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    chk_rd("single_idle", 1'b0, 5'd5, 32'hDEADBEEF);
    // wide write from source 1 at odd address
    src1(1'b1, 1'b1, 5'd7, 32'h11111111, 32'h22222222);
    #1 chk_rdy("wide", 1'b0, 1'b1);
    tick();
    chk_rd("wide_even", 1'b1, 5'd6, 32'h11111111);
    chk("wide_busy", 32'(busy_hi), 32'd1);
    src0(1'b1, 1'b0, 5'd9, 32'h99, 32'h0);
    src1(1'b1, 1'b0, 5'd12, 32'hC0, 32'h0);
    #1 chk_rdy("wide_hold", 1'b0, 1'b0);
    tick();
    chk_rd("wide_odd", 1'b1, 5'd7, 32'h22222222);
    chk("wide_busy_clr", 32'(busy_hi), 32'd0);
    // continuous contention: grants alternate starting with source 0
    for (int i = 0; i < 6; i++) begin
      chk_rdy($sformatf("cont%0d", i), (i % 2) == 0, (i % 2) == 1);
      tick();
      if ((i % 2) == 0) chk_rd($sformatf("cont%0d", i), 1'b1, 5'd9, 32'h99);
      else chk_rd($sformatf("cont%0d", i), 1'b1, 5'd12, 32'hC0);
    end
    src0(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    src1(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    chk_rd("cont_idle", 1'b0, 5'd12, 32'hC0);
    // wide from source 0 against single from source 1
    src0(1'b1, 1'b1, 5'd10, 32'hA0, 32'hA1);
    src1(1'b1, 1'b0, 5'd3, 32'h33, 32'h0);
    #1 chk_rdy("wvs", 1'b1, 1'b0);
    tick();
    src0(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    chk_rd("wvs_even", 1'b1, 5'd10, 32'hA0);
    #1 chk_rdy("wvs_hold", 1'b0, 1'b0);
    tick();
    chk_rd("wvs_odd", 1'b1, 5'd11, 32'hA1);
    chk_rdy("wvs_s1", 1'b0, 1'b1);
    tick();
    src1(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    chk_rd("wvs_single", 1'b1, 5'd3, 32'h33);
    // x0 single write is suppressed but occupies its slot
    src0(1'b1, 1'b0, 5'd0, 32'h55, 32'h0);
    #1 chk_rdy("x0s", 1'b1, 1'b0);
    tick();
    src0(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    chk_rd("x0s_wr", 1'b0, 5'd0, 32'h55);
    // wide write to pair 0 writes only x1
    src0(1'b1, 1'b1, 5'd0, 32'h77, 32'hCAFE);
    #1 chk_rdy("x0w", 1'b1, 1'b0);
    tick();
    src0(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    chk_rd("x0w_even", 1'b0, 5'd0, 32'h77);
    chk("x0w_busy", 32'(busy_hi), 32'd1);
    tick();
    chk_rd("x0w_odd", 1'b1, 5'd1, 32'hCAFE);
    // reset in the middle of a pair discards the odd half
    src1(1'b1, 1'b1, 5'd20, 32'h2020, 32'h2121);
    #1 chk_rdy("rst_wide", 1'b0, 1'b1);
    tick();
    src1(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    chk_rd("rst_even", 1'b1, 5'd20, 32'h2020);
    chk("rst_busy", 32'(busy_hi), 32'd1);
    resetn = 1'b0;
    #1;
    chk_rd("rst_async", 1'b0, 5'd0, 32'd0);
    chk("rst_async_busy", 32'(busy_hi), 32'd0);
    tick();
    #2 resetn = 1'b1;
    tick();
    chk_rd("rst_no_odd", 1'b0, 5'd0, 32'd0);
    chk("rst_busy_after", 32'(busy_hi), 32'd0);
    src0(1'b1, 1'b0, 5'd2, 32'h202, 32'h0);
    src1(1'b1, 1'b0, 5'd4, 32'h404, 32'h0);
    #1 chk_rdy("rst_tie", 1'b1, 1'b0);
    tick();
    chk_rd("rst_tie_wr", 1'b1, 5'd2, 32'h202);
    src0(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    src1(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/xc_rf_wb_arb.md
# xc_rf_wb_arb

Write-port arbiter and sequencer for the 3-read / 1-write general-purpose register file. Two writeback sources share the file's single write port through this block:

- **Source 0:** the single-cycle execute path.
- **Source 1:** the multi-cycle unit (multiply, load, crypto ops).

Either source may request a 32-bit write or a 64-bit paired write to an even/odd register pair. A paired write is split into two consecutive write-port cycles that cannot be interrupted. The write-port outputs are registered and drive the register file's `rd_wen`/`rd_addr`/`rd_wdata` directly.

## Interface

Parameters:
- None. All widths are fixed: 5-bit register address, 32-bit data.

Ports:
- `clock`  in  1  single clock; all state is updated on the rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `s0_valid`  in  1  source 0 has a write request.
- `s0_ready`  out  1  source 0 request accepted this cycle.
- `s0_wide`  in  1  1 = paired 64-bit write, 0 = single 32-bit write.
- `s0_addr`  in  5  destination register. For a wide write, bit 0 is ignored.
- `s0_wdata_lo`  in  32  data for a single write, or for the even register of a pair.
- `s0_wdata_hi`  in  32  data for the odd register of a pair; ignored when `s0_wide`=0.
- `s1_valid`, `s1_ready`, `s1_wide`, `s1_addr`, `s1_wdata_lo`, `s1_wdata_hi`  same as the source 0 ports, for source 1.
- `rd_wen`  out  1  register-file write enable (registered).
- `rd_addr`  out  5  register-file write address (registered).
- `rd_wdata`  out  32  register-file write data (registered).
- `busy_hi`  out  1  1 while the odd half of a pair is still pending (state LO).

## Operation

**State registers**
- FSM states: IDLE, WR, LO.
- `last`: the source that won the previous arbitration.
- `hi_addr` (5 bits) and `hi_data` (32 bits): the pending odd half of a pair.

**Ready / grant**
- `hold = (state == LO)`.
- `s0_ready = !hold && s0_valid && (!s1_valid || last == 1)`.
- `s1_ready = !hold && s1_valid && (!s0_valid || last == 0)`.
- At most one `ready` is asserted per cycle. `ready` is never asserted without the matching `valid`.
- Arbitration is round-robin. `last` updates to the winner on every accept and holds otherwise.

**On accepting a single write (`wide`=0)**
- Next cycle: `rd_addr = addr`, `rd_wdata = wdata_lo`, `rd_wen = (addr != 0)`.
- Next state: WR.

**On accepting a wide write**
- Base address: `p = {addr[4:1], 0}`.
- Next cycle: `rd_addr = p`, `rd_wdata = wdata_lo`, `rd_wen = (p != 0)`.
- Latch `hi_addr = p | 1` and `hi_data = wdata_hi`.
- Next state: LO.

**In LO**
- No accept is possible.
- Next cycle: `rd_addr = hi_addr`, `rd_wdata = hi_data`, `rd_wen = 1`. The odd register is never x0.
- Next state: WR.

**No accept while not in LO**
- `rd_wen = 0`. `rd_addr` and `rd_wdata` hold their previous values.
- Next state: IDLE.

**Register x0 handling**
- Writes to x0 still consume their slot in the sequence, but `rd_wen` stays 0 for that slot.
- A wide write to pair 0 therefore writes only x1.

**Source contract**
- A source must hold its request fields stable while `valid`=1 and `ready`=0. The block does not check this.

## Timing

- **Reset values:** `rd_wen`=0, `rd_addr`=0, `rd_wdata`=0, `busy_hi`=0, state=IDLE, `last`=1, `hi_addr`=0, `hi_data`=0.
  - Because `last`=1 after reset, source 0 wins the first tie.
- **Single-write latency:** accepted in cycle N; `rd_*` is valid in cycle N+1; the register file updates on the edge that ends N+1.
- **Wide-write latency:** accepted in cycle N; even half in N+1; odd half in N+2.
  - Both `ready` outputs are 0 in cycle N+1.
  - The next accept can occur in N+2, so its write appears in N+3.
- **Throughput:**
  - Back-to-back single writes: 1 per cycle.
  - Wide writes: 1 pair per 2 cycles.
- **Simultaneous requests:**
  - Under continuous contention the winners alternate 0, 1, 0, 1, …
  - A wide winner blocks the loser for one extra cycle.
  - Neither source waits more than 3 cycles once its `valid` is high.
- **Reset mid-operation:** assertion immediately clears `rd_wen`, `busy_hi` and the state.
  - A pending odd half is discarded and is never written.
  - Requests resume in the first cycle after deassertion.

## Test plan

- **Single write:** reset, then `s0_valid`=1, `addr`=5, `lo`=0xDEADBEEF for one cycle → `s0_ready`=1 in that cycle; next cycle `rd_wen`=1, `rd_addr`=5, `rd_wdata`=0xDEADBEEF; then `rd_wen`=0.
- **Wide write, odd address:** `s1_valid`=1, `wide`=1, `addr`=7, `lo`=0x11111111, `hi`=0x22222222 → `rd` sequence is (6, 0x11111111), then (7, 0x22222222) on consecutive cycles; `busy_hi`=1 and both `ready`=0 during the first of those cycles.
- **Continuous contention:** both sources valid with single writes for 6 cycles → grant order 0, 1, 0, 1, 0, 1; `rd_addr` alternates between the two sources' addresses; `rd_wen`=1 every cycle.
- **Wide vs single contention:** source 0 wide (`addr`=10), source 1 single (`addr`=3), both valid → writes 10, 11, then 3; `s1_ready` first rises 2 cycles after `s0_ready`.
- **x0 suppression:** a single write to `addr`=0 gives a cycle with `rd_wen`=0. A wide write to `addr`=0 with `hi`=0xCAFE gives `rd_wen`=0 on the first slot, then `rd_wen`=1, `rd_addr`=1, `rd_wdata`=0xCAFE.
- **Reset mid-pair:** assert `resetn`=0 in the cycle `busy_hi`=1 → `rd_wen`=0 and `busy_hi`=0 immediately; after release, no write to the odd register ever appears; the first tie goes to source 0.
